nes_joypad_target: RTL and testbench
====================================

NES_JOYPAD_TARGET -- requirements
Module: nes_joypad_target

Interface
REQ-001 Parameter ADDRESS, default 7'h52, 7-bit bus address the block answers to.
REQ-002 Parameter POLL_PERIOD, default 33333, clk cycles between successive controller poll starts; SHALL exceed 18*NES_HALF.
REQ-003 Parameter NES_HALF, default 12, clk cycles per half-period of nes_latch/nes_clk; SHALL be at least 4.
REQ-004 clk  in  1  single block clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 scl_in  in  1  serial clock from bus initiator.
REQ-007 sda_in  in  1  serial data line as seen on bus.
REQ-008 sda_out  out  1  open-drain drive; 0 = pull SDA low, 1 = release.
REQ-009 nes_latch  out  1  controller latch, active-high.
REQ-010 nes_clk  out  1  controller shift clock.
REQ-011 nes_data  in  1  controller serial data, active-low buttons.
REQ-012 joypad  out  8  last complete sample, active-low: [7]A [6]B [5]Select [4]Start [3]Up [2]Down [1]Left [0]Right.
REQ-013 joypad_valid  out  1  one-cycle pulse when joypad updates.

Function
REQ-014 scl_in, sda_in, nes_data SHALL each pass a 2-flop synchronizer; all edge/condition detection uses synchronized values.
REQ-015 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both detected in any bus state.
REQ-016 Bus FSM states: IDLE, ADDR, ACK, SEND, WAIT_ACK.
REQ-017 IDLE: sda_out=1; START -> ADDR with bit counter cleared.
REQ-018 ADDR: shift SDA in MSB first on each SCL rise; after 8th rise, byte = {ADDRESS,1'b1} -> ACK, else -> IDLE (ignore until next START).
REQ-019 ACK: on first SCL fall drive sda_out=0 and snapshot joypad into tx shift register; on next SCL fall -> SEND.
REQ-020 SEND: on entry and on each SCL fall drive next tx bit MSB first (sda_out=bit); after 8th bit's SCL fall release sda_out -> WAIT_ACK.
REQ-021 WAIT_ACK: sample SDA on SCL rise; 0 (ACK) -> re-snapshot joypad, SEND again from bit 7; 1 (NACK) -> IDLE.
REQ-022 STOP in any state -> IDLE, sda_out=1 same cycle as detection; START in any state (repeated start) -> ADDR.
REQ-023 sda_out changes only while synchronized SCL low, except release on STOP/reset.
REQ-024 Snapshot SHALL be atomic: joypad updates during SEND never alter bits in flight.
REQ-025 Poll FSM states: WAIT, LATCH, SAMPLE, PULSE; poll counter wraps at POLL_PERIOD-1.
REQ-026 Poll start at counter 0: nes_latch=1 for NES_HALF cycles, then 0.
REQ-027 After latch falls wait NES_HALF cycles, sample nes_data into bit 7; then per remaining bit: nes_clk=1 NES_HALF cycles, nes_clk=0 NES_HALF cycles, sample into next lower bit; 7 clk pulses total.
REQ-028 After 8th sample joypad <= assembled byte and joypad_valid=1 for exactly one cycle; back to WAIT.
REQ-029 Poll and bus FSMs run independently; a poll completing in the same cycle as a snapshot delivers the old joypad value.

Reset
REQ-030 While rst=1: sda_out=1, nes_latch=0, nes_clk=0, joypad=8'hFF, joypad_valid=0, both FSMs idle, poll counter 0, synchronizers 1 (scl/sda) and 1 (nes_data).
REQ-031 First poll starts on first clk edge after rst deasserts; reset mid-transfer releases SDA immediately and aborts the poll.

Verification
REQ-032 Controller model holds A and Left pressed; after first poll -> joypad=8'h7D, one joypad_valid pulse, 7 nes_clk pulses, latch width NES_HALF.
REQ-033 Initiator sends START, 8'hA5 ({7'h52,1}), clocks 9 more bits, NACK, STOP -> ACK low on 9th clock, received byte 8'h7D, sda_out=1 after STOP.
REQ-034 Address 8'hA4 (write) or 8'hA7 (wrong addr) -> sda_out stays 1 through entire transfer.
REQ-035 Initiator ACKs first byte, change buttons between bytes -> second byte reflects joypad at WAIT_ACK ACK; joypad update mid-byte does not corrupt first byte.
REQ-036 STOP after 3 data bits, then repeated START mid-byte -> sda_out released at once, next transfer served correctly.
REQ-037 Assert rst during SEND with sda_out=0 -> sda_out=1, joypad=8'hFF immediately, asynchronous to clk.

Source files
------------

// File: rtl/nes_joypad_target.sv
// NES controller poller with a read-only serial-bus target.
// The poll engine samples the pad every POLL_PERIOD cycles. Every bus read
// addressed to {ADDRESS,1} returns the most recent sample. The target keeps
// returning a fresh snapshot for as long as the initiator ACKs each byte.
module nes_joypad_target #(
   parameter logic [6:0] ADDRESS     = 7'h52,
   parameter int         POLL_PERIOD = 33333,
   parameter int         NES_HALF    = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_out,
   output logic       nes_latch,
   output logic       nes_clk,
   input  logic       nes_data,
   output logic [7:0] joypad,
   output logic       joypad_valid
);

   localparam int            PW        = $clog2(POLL_PERIOD);
   localparam int            HW        = $clog2(NES_HALF);
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(NES_HALF - 1);

   typedef enum logic [2:0] {B_IDLE, B_ADDR, B_ACK, B_SEND, B_WAIT_ACK} bus_state_t;
   typedef enum logic [1:0] {P_WAIT, P_LATCH, P_SAMPLE, P_PULSE} poll_state_t;

   logic          r_scl_meta, r_scl_sync, r_scl_prev;
   logic          r_sda_meta, r_sda_sync, r_sda_prev;
   logic          r_nes_meta, r_nes_sync;
   logic          w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [7:0]    w_rx_byte;

   bus_state_t    r_bus_state, w_bus_next;
   logic [3:0]    r_bit_cnt;
   logic [6:0]    r_rx_shift;
   logic [7:0]    r_tx_shift;
   logic          r_sda_drv;

   poll_state_t   r_poll_state, w_poll_next;
   logic [PW-1:0] r_poll_cnt;
   logic [HW-1:0] r_tmr;
   logic          w_half_done;
   logic [2:0]    r_smp_idx;
   logic [6:0]    r_rx_pad;
   logic [7:0]    r_joypad;
   logic          r_valid;

   // Input synchronizers plus a history flop for edge and condition detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl_meta <= 1'b1;
         r_scl_sync <= 1'b1;
         r_scl_prev <= 1'b1;
         r_sda_meta <= 1'b1;
         r_sda_sync <= 1'b1;
         r_sda_prev <= 1'b1;
         r_nes_meta <= 1'b1;
         r_nes_sync <= 1'b1;
      end else begin
         // NOTE: non-blocking so every flop in the chain samples its pre-edge input.
         r_scl_meta <= scl_in;
         r_scl_sync <= r_scl_meta;
         r_scl_prev <= r_scl_sync;
         r_sda_meta <= sda_in;
         r_sda_sync <= r_sda_meta;
         r_sda_prev <= r_sda_sync;
         r_nes_meta <= nes_data;
         r_nes_sync <= r_nes_meta;
      end
   end

   assign w_scl_rise = r_scl_sync & ~r_scl_prev;
   assign w_scl_fall = ~r_scl_sync & r_scl_prev;
   assign w_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
   assign w_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
   assign w_rx_byte  = {r_rx_shift, r_sda_sync};

   // Bus FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_bus_state <= B_IDLE;
      else     r_bus_state <= w_bus_next;
   end

   // Bus FSM next state. STOP and START override every state.
   always_comb begin
      // NOTE: default first so no path through the case leaves a latch.
      w_bus_next = r_bus_state;
      if (w_stop) begin
         w_bus_next = B_IDLE;
      end else if (w_start) begin
         w_bus_next = B_ADDR;
      end else begin
         case (r_bus_state)
            B_ADDR:
               if (w_scl_rise && r_bit_cnt == 4'd7)
                  w_bus_next = (w_rx_byte == {ADDRESS, 1'b1}) ? B_ACK : B_IDLE;
            B_ACK:
               if (w_scl_fall && r_bit_cnt != 4'd0) w_bus_next = B_SEND;
            B_SEND:
               if (w_scl_fall && r_bit_cnt == 4'd8) w_bus_next = B_WAIT_ACK;
            B_WAIT_ACK:
               if (w_scl_rise) w_bus_next = r_sda_sync ? B_IDLE : B_SEND;
            default: ;
         endcase
      end
   end

   // Bus datapath: address shift-in, snapshot, and bit-serial transmit.
   // All drive changes follow a detected SCL fall, so SDA moves only while SCL is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt  <= 4'd0;
         r_rx_shift <= 7'd0;
         r_tx_shift <= 8'hFF;
         r_sda_drv  <= 1'b1;
      end else if (w_stop) begin
         r_sda_drv <= 1'b1;
      end else if (w_start) begin
         r_sda_drv <= 1'b1;
         r_bit_cnt <= 4'd0;
      end else begin
         case (r_bus_state)
            B_ADDR:
               if (w_scl_rise) begin
                  r_rx_shift <= w_rx_byte[6:0];
                  r_bit_cnt  <= (r_bit_cnt == 4'd7) ? 4'd0 : r_bit_cnt + 4'd1;
               end
            B_ACK:
               if (w_scl_fall) begin
                  r_bit_cnt <= 4'd1;
                  if (r_bit_cnt == 4'd0) begin
                     r_sda_drv  <= 1'b0;
                     r_tx_shift <= r_joypad;
                  end else begin
                     r_sda_drv  <= r_tx_shift[7];
                     r_tx_shift <= {r_tx_shift[6:0], 1'b1};
                  end
               end
            B_SEND:
               if (w_scl_fall) begin
                  if (r_bit_cnt == 4'd8) begin
                     r_sda_drv <= 1'b1;
                  end else begin
                     r_sda_drv  <= r_tx_shift[7];
                     r_tx_shift <= {r_tx_shift[6:0], 1'b1};
                     r_bit_cnt  <= r_bit_cnt + 4'd1;
                  end
               end
            B_WAIT_ACK:
               if (w_scl_rise && !r_sda_sync) begin
                  r_tx_shift <= r_joypad;
                  r_bit_cnt  <= 4'd0;
               end
            default: ;
         endcase
      end
   end

   // Bus output. SDA is released in the same cycle that STOP is detected.
   always_comb begin
      sda_out = r_sda_drv | w_stop;
   end

   // Free-running poll period counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_poll_cnt <= '0;
      else     r_poll_cnt <= (r_poll_cnt == POLL_LAST) ? '0 : r_poll_cnt + 1'b1;
   end

   assign w_half_done = (r_tmr == HALF_LAST);

   // Poll FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_poll_state <= P_WAIT;
      else     r_poll_state <= w_poll_next;
   end

   // Poll FSM next state: latch, then alternate sample-wait and clock-high phases.
   always_comb begin
      w_poll_next = r_poll_state;
      case (r_poll_state)
         P_WAIT:   if (r_poll_cnt == '0) w_poll_next = P_LATCH;
         P_LATCH:  if (w_half_done) w_poll_next = P_SAMPLE;
         P_SAMPLE: if (w_half_done) w_poll_next = (r_smp_idx == 3'd0) ? P_WAIT : P_PULSE;
         P_PULSE:  if (w_half_done) w_poll_next = P_SAMPLE;
         default:  w_poll_next = P_WAIT;
      endcase
   end

   // Poll datapath: half-period timer, bit index, sample assembly, joypad update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmr     <= '0;
         r_smp_idx <= 3'd7;
         r_rx_pad  <= 7'h7F;
         r_joypad  <= 8'hFF;
         r_valid   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (r_poll_state == P_WAIT || w_half_done) r_tmr <= '0;
         else                                       r_tmr <= r_tmr + 1'b1;
         if (r_poll_state == P_WAIT) r_smp_idx <= 3'd7;
         if (r_poll_state == P_SAMPLE && w_half_done) begin
            r_rx_pad  <= {r_rx_pad[5:0], r_nes_sync};
            r_smp_idx <= r_smp_idx - 3'd1;
            if (r_smp_idx == 3'd0) begin
               r_joypad <= {r_rx_pad, r_nes_sync};
               r_valid  <= 1'b1;
            end
         end
      end
   end

   // Poll outputs decoded from state.
   always_comb begin
      nes_latch    = (r_poll_state == P_LATCH);
      nes_clk      = (r_poll_state == P_PULSE);
      joypad       = r_joypad;
      joypad_valid = r_valid;
   end

endmodule

// File: tb/tb_nes_joypad_target.sv
// Directed bench for nes_joypad_target: controller model on the pad side and
// a bit-banged initiator on the bus side, with the bus modelled as a wired-AND.
module tb_nes_joypad_target;

   localparam int NES_HALF    = 4;
   localparam int POLL_PERIOD = 200;
   localparam int Q           = 5;   // clk cycles per quarter SCL period

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_in = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_in;
   logic       sda_out;
   logic       nes_latch;
   logic       nes_clk;
   logic       nes_data;
   logic [7:0] joypad;
   logic       joypad_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign sda_in = sda_m & sda_out;

   nes_joypad_target #(
      .ADDRESS    (7'h52),
      .POLL_PERIOD(POLL_PERIOD),
      .NES_HALF   (NES_HALF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .scl_in      (scl_in),
      .sda_in      (sda_in),
      .sda_out     (sda_out),
      .nes_latch   (nes_latch),
      .nes_clk     (nes_clk),
      .nes_data    (nes_data),
      .joypad      (joypad),
      .joypad_valid(joypad_valid)
   );

   // Controller model: parallel load while latched, shift on each clock rise.
   logic [7:0] buttons = 8'h7D;
   logic [7:0] ctl_sh  = 8'hFF;
   always @(posedge nes_latch or posedge nes_clk) begin
      if (nes_latch) ctl_sh <= buttons;
      else           ctl_sh <= {ctl_sh[6:0], 1'b1};
   end
   assign nes_data = ctl_sh[7];

   // Activity monitors.
   int n_clk_pulses = 0;
   int n_latch_cyc  = 0;
   int n_clkhi_cyc  = 0;
   int n_valid_cyc  = 0;
   int n_sda_low    = 0;
   always @(posedge nes_clk) n_clk_pulses <= n_clk_pulses + 1;
   always @(negedge clk) begin
      if (nes_latch)    n_latch_cyc <= n_latch_cyc + 1;
      if (nes_clk)      n_clkhi_cyc <= n_clkhi_cyc + 1;
      if (joypad_valid) n_valid_cyc <= n_valid_cyc + 1;
      if (!sda_out)     n_sda_low   <= n_sda_low + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (joypad_valid !== 1'b1 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_timeout"}, 32'(k < 1000), 32'd1);
      @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1;  tick(Q);
      scl_in = 1'b1; tick(Q);
      sda_m = 1'b0;  tick(Q);
      scl_in = 1'b0; tick(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0;  tick(Q);
      scl_in = 1'b1; tick(Q);
      sda_m = 1'b1;  tick(Q);
   endtask

   task automatic put_bit(input logic b);
      sda_m = b;     tick(Q);
      scl_in = 1'b1; tick(2 * Q);
      scl_in = 1'b0; tick(Q);
   endtask

   task automatic put_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) put_bit(v[i]);
   endtask

   task automatic get_bits(input int n, output logic [7:0] v);
      logic b;
      v = 8'h00;
      for (int i = 0; i < n; i++) begin
         sda_m = 1'b1;  tick(Q);
         scl_in = 1'b1; tick(Q);
         b = sda_in;    tick(Q);
         scl_in = 1'b0; tick(Q);
         v = {v[6:0], b};
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ack;
      logic [7:0] byt;
      logic [7:0] addr;
      int         lows;

      // Reset state.
      tick(3);
      check("rst_sda_out", 32'(sda_out), 32'd1);
      check("rst_nes_latch", 32'(nes_latch), 32'd0);
      check("rst_nes_clk", 32'(nes_clk), 32'd0);
      check("rst_joypad", 32'(joypad), 32'hFF);
      check("rst_valid", 32'(joypad_valid), 32'd0);
      rst = 1'b0;

      // First poll with A and Left pressed.
      wait_valid("poll1");
      check("poll1_joypad", 32'(joypad), 32'h7D);
      check("poll1_valid_cycles", 32'(n_valid_cyc), 32'd1);
      check("poll1_clk_pulses", 32'(n_clk_pulses), 32'd7);
      check("poll1_latch_width", 32'(n_latch_cyc), 32'(NES_HALF));
      check("poll1_clk_high", 32'(n_clkhi_cyc), 32'(7 * NES_HALF));

      // Single-byte read, NACK, STOP.
      bus_start();
      put_byte(8'hA5);
      get_bits(1, ack);
      check("rd_ack", 32'(ack), 32'd0);
      get_bits(8, byt);
      check("rd_byte", 32'(byt), 32'h7D);
      put_bit(1'b1);
      bus_stop();
      check("rd_stop_release", 32'(sda_out), 32'd1);

      // Write address and wrong address are ignored.
      for (int i = 0; i < 2; i++) begin
         addr = (i == 0) ? 8'hA4 : 8'hA7;
         lows = n_sda_low;
         bus_start();
         put_byte(addr);
         get_bits(1, ack);
         check("bad_addr_ack", 32'(ack), 32'd1);
         get_bits(8, byt);
         check("bad_addr_byte", 32'(byt), 32'hFF);
         put_bit(1'b1);
         bus_stop();
         check("bad_addr_sda_low_cycles", 32'(n_sda_low - lows), 32'd0);
      end

      // Two-byte read with pad changes mid-byte and between bytes.
      bus_start();
      put_byte(8'hA5);
      get_bits(1, ack);
      check("two_ack", 32'(ack), 32'd0);
      get_bits(2, byt);
      check("two_first_head", 32'(byt), 32'h01);
      wait_valid("mid_sync");
      buttons = 8'hEF;
      wait_valid("mid_poll");
      check("mid_joypad", 32'(joypad), 32'hEF);
      get_bits(6, byt);
      check("two_first_tail", 32'(byt), 32'h3D);
      wait_valid("gap_sync");
      buttons = 8'hFA;
      wait_valid("gap_poll");
      check("gap_joypad", 32'(joypad), 32'hFA);
      put_bit(1'b0);
      get_bits(8, byt);
      check("two_second_byte", 32'(byt), 32'hFA);
      put_bit(1'b1);
      bus_stop();
      check("two_stop_release", 32'(sda_out), 32'd1);

      // STOP after three data bits, then a fresh transfer.
      bus_start();
      put_byte(8'hA5);
      get_bits(1, ack);
      check("abort_ack", 32'(ack), 32'd0);
      get_bits(3, byt);
      check("abort_head", 32'(byt), 32'h07);
      bus_stop();
      check("abort_stop_release", 32'(sda_out), 32'd1);
      bus_start();
      put_byte(8'hA5);
      get_bits(1, ack);
      check("after_stop_ack", 32'(ack), 32'd0);
      get_bits(3, byt);
      check("restart_head", 32'(byt), 32'h07);

      // Repeated START in the middle of a byte.
      bus_start();
      check("restart_release", 32'(sda_out), 32'd1);
      put_byte(8'hA5);
      get_bits(1, ack);
      check("restart_ack", 32'(ack), 32'd0);
      get_bits(8, byt);
      check("restart_byte", 32'(byt), 32'hFA);
      put_bit(1'b1);
      bus_stop();

      // Asynchronous reset while the target drives SDA low.
      bus_start();
      put_byte(8'hA5);
      get_bits(1, ack);
      get_bits(5, byt);
      check("pre_rst_head", 32'(byt), 32'h1F);
      check("pre_rst_drive_low", 32'(sda_out), 32'd0);
      #1 rst = 1'b1;
      #1;
      check("rst_async_sda", 32'(sda_out), 32'd1);
      check("rst_async_joypad", 32'(joypad), 32'hFF);
      check("rst_async_latch", 32'(nes_latch), 32'd0);
      scl_in = 1'b1;
      sda_m  = 1'b1;
      tick(3);
      rst = 1'b0;
      wait_valid("post_rst_poll");
      check("post_rst_joypad", 32'(joypad), 32'hFA);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
